// File: rtl/term_pkg.sv
// Shared geometry, pipeline depth and sideband types for the text-mode display path.
package term_pkg;

    localparam int unsigned COLS       = 80;
    localparam int unsigned ROWS       = 40;
    localparam int unsigned CELL_W     = 8;
    localparam int unsigned CELL_H     = 12;
    localparam int unsigned TEXT_DEPTH = 3200;
    localparam int unsigned PIPE_LAT   = 5;

    localparam int unsigned BLINK_BIT_DEF = 5;
    localparam int unsigned FRAME_W       = 8;

    localparam int unsigned COL_W  = $clog2(COLS);
    localparam int unsigned ROW_W  = $clog2(ROWS);
    localparam int unsigned ADDR_W = $clog2(TEXT_DEPTH);
    localparam int unsigned PHASE_W = $clog2(CELL_W);

    // Per-pixel sideband carried alongside the memory lookups.
    typedef struct packed {
        logic [PHASE_W-1:0] phase;
        logic               hit;
        logic               vis;
        logic               disp;
        logic               hsync;
        logic               vsync;
    } pix_ctl_t;

endpackage

// File: rtl/text_cell_tracker.sv
// Tracks text row, glyph line and frame count from changes in the beam line number.
module text_cell_tracker
    import term_pkg::*;
(
    input  logic               clk,
    input  logic               reset_n,
    input  logic [9:0]         vpos,
    output logic [ROW_W-1:0]   cell_row,
    output logic [3:0]         yofs,
    output logic [FRAME_W-1:0] frame_cnt,
    output logic               synced
);

    logic [9:0]         prev_vpos_q;
    logic [ROW_W-1:0]   cell_row_q;
    logic [3:0]         yofs_q;
    logic [FRAME_W-1:0] frame_cnt_q;
    logic               synced_q;

    // Outputs reflect the current vpos, so the first pixel of a new line already
    // sees the updated row/line.
    always_comb begin
        cell_row  = cell_row_q;
        yofs      = yofs_q;
        frame_cnt = frame_cnt_q;
        synced    = synced_q;
        if (vpos != prev_vpos_q) begin
            if (vpos == '0) begin
                cell_row  = '0;
                yofs      = '0;
                frame_cnt = frame_cnt_q + 1'b1;
                synced    = 1'b1;
            end else if (yofs_q == 4'(CELL_H - 1)) begin
                yofs = '0;
                if (cell_row_q != '1) begin
                    cell_row = cell_row_q + 1'b1;
                end
            end else begin
                yofs = yofs_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_vpos_q <= '0;
            cell_row_q  <= '0;
            yofs_q      <= '0;
            frame_cnt_q <= '0;
            synced_q    <= 1'b0;
        end else begin
            prev_vpos_q <= vpos;
            cell_row_q  <= cell_row;
            yofs_q      <= yofs;
            frame_cnt_q <= frame_cnt;
            synced_q    <= synced;
        end
    end

endmodule

// File: rtl/text_cell_renderer.sv
// Text-mode renderer: beam position -> text RAM -> font ROM -> serialized pixel with
// blinking inverse cursor; syncs delayed to match the lookup pipeline.
module text_cell_renderer
    import term_pkg::*;
#(
    parameter int unsigned BLINK_BIT = BLINK_BIT_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [9:0]        hpos,
    input  logic [9:0]        vpos,
    input  logic              display_on_in,
    input  logic              hsync_in,
    input  logic              vsync_in,
    output logic [ADDR_W-1:0] text_addr,
    input  logic [7:0]        text_data,
    output logic [7:0]        font_char,
    output logic [3:0]        font_yofs,
    input  logic [7:0]        font_bits,
    input  logic              cursor_en,
    input  logic [COL_W-1:0]  cursor_col,
    input  logic [ROW_W-1:0]  cursor_row,
    output logic              pixel,
    output logic              hsync_out,
    output logic              vsync_out,
    output logic              display_on_out
);

    logic [ROW_W-1:0]   cell_row;
    logic [3:0]         yofs;
    logic [FRAME_W-1:0] frame_cnt;
    logic               synced;

    text_cell_tracker u_tracker (
        .clk       (clk),
        .reset_n   (reset_n),
        .vpos      (vpos),
        .cell_row  (cell_row),
        .yofs      (yofs),
        .frame_cnt (frame_cnt),
        .synced    (synced)
    );

    logic [COL_W-1:0]  col;
    logic [ADDR_W-1:0] addr_d;
    logic              blink;
    pix_ctl_t          ctl_d;

    assign col   = hpos[9:PHASE_W];
    assign blink = |(frame_cnt & FRAME_W'(1 << BLINK_BIT));

    // row*80 + col as shift-add
    always_comb begin
        addr_d = {cell_row, 6'b0} + {2'b0, cell_row, 4'b0} + {5'b0, col};
    end

    always_comb begin
        ctl_d       = '0;
        ctl_d.phase = hpos[PHASE_W-1:0];
        ctl_d.hit   = cursor_en & blink & (col == cursor_col) & (cell_row == cursor_row);
        ctl_d.vis   = display_on_in & synced;
        ctl_d.disp  = display_on_in;
        ctl_d.hsync = hsync_in;
        ctl_d.vsync = vsync_in;
    end

    logic [ADDR_W-1:0] text_addr_q;
    logic [3:0]        yofs1_q, yofs2_q, font_yofs_q;
    logic [7:0]        font_char_q;
    pix_ctl_t          ctl_q [PIPE_LAT-1];
    pix_ctl_t          ctl_last;
    logic              pixel_q, hsync_q, vsync_q, disp_q;

    assign ctl_last = ctl_q[PIPE_LAT-2];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            text_addr_q <= '0;
            yofs1_q     <= '0;
            yofs2_q     <= '0;
            font_char_q <= '0;
            font_yofs_q <= '0;
            for (int unsigned i = 0; i < PIPE_LAT - 1; i++) begin
                ctl_q[i] <= '0;
            end
            pixel_q     <= 1'b0;
            hsync_q     <= 1'b0;
            vsync_q     <= 1'b0;
            disp_q      <= 1'b0;
        end else begin
            // Holding during blanking keeps the address inside the text RAM.
            if (display_on_in) begin
                text_addr_q <= addr_d;
            end
            yofs1_q     <= yofs;
            yofs2_q     <= yofs1_q;
            font_char_q <= text_data;
            font_yofs_q <= yofs2_q;
            ctl_q[0]    <= ctl_d;
            for (int unsigned i = 1; i < PIPE_LAT - 1; i++) begin
                ctl_q[i] <= ctl_q[i-1];
            end
            pixel_q <= ctl_last.vis & (font_bits[3'd7 - ctl_last.phase] ^ ctl_last.hit);
            hsync_q <= ctl_last.hsync;
            vsync_q <= ctl_last.vsync;
            disp_q  <= ctl_last.disp;
        end
    end

    assign text_addr      = text_addr_q;
    assign font_char      = font_char_q;
    assign font_yofs      = font_yofs_q;
    assign pixel          = pixel_q;
    assign hsync_out      = hsync_q;
    assign vsync_out      = vsync_q;
    assign display_on_out = disp_q;

endmodule

// File: tb/tb_text_cell_renderer.sv
// Randomized bench for text_cell_renderer against a line/cell arithmetic reference model.
module tb_text_cell_renderer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [9:0]  hpos = '0, vpos = '0;
    logic        display_on_in = 1'b0, hsync_in = 1'b0, vsync_in = 1'b0;
    logic [11:0] text_addr;
    logic [7:0]  text_data = '0;
    logic [7:0]  font_char;
    logic [3:0]  font_yofs;
    logic [7:0]  font_bits = '0;
    logic        cursor_en = 1'b0;
    logic [6:0]  cursor_col = '0;
    logic [5:0]  cursor_row = '0;
    logic        pixel, hsync_out, vsync_out, display_on_out;

    always #5 clk = ~clk;

    text_cell_renderer dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .hpos           (hpos),
        .vpos           (vpos),
        .display_on_in  (display_on_in),
        .hsync_in       (hsync_in),
        .vsync_in       (vsync_in),
        .text_addr      (text_addr),
        .text_data      (text_data),
        .font_char      (font_char),
        .font_yofs      (font_yofs),
        .font_bits      (font_bits),
        .cursor_en      (cursor_en),
        .cursor_col     (cursor_col),
        .cursor_row     (cursor_row),
        .pixel          (pixel),
        .hsync_out      (hsync_out),
        .vsync_out      (vsync_out),
        .display_on_out (display_on_out)
    );

    // Environment memories: text RAM and font ROM with 1-cycle registered reads.
    logic [7:0] tmem [3200];
    logic [7:0] rom  [3072];

    always @(posedge clk) begin
        text_data <= (text_addr < 12'd3200) ? tmem[text_addr] : 8'h00;
        font_bits <= (font_yofs < 4'd12) ? rom[int'(font_char) * 12 + int'(font_yofs)] : 8'h00;
    end

    typedef struct {
        bit pix, hs, vs, disp, chk_addr, chk_font;
        int addr, yofs, fch;
    } exp_t;

    exp_t hist [8];
    int   t = 0;
    int   n_checks = 0, n_pass = 0;
    int   m_prev, m_frames, m_last;
    bit   m_synced;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0d, vpos=%0d, hpos=%0d)",
                      tag, got, exp, t, vpos, hpos);
    endtask

    function automatic exp_t zero_entry();
        exp_t e;
        e = '{pix: 0, hs: 0, vs: 0, disp: 0, chk_addr: 1, chk_font: 0, addr: 0, yofs: 0, fch: 0};
        return e;
    endfunction

    function automatic void model_reset();
        m_prev = 0; m_frames = 0; m_last = 0; m_synced = 0;
        for (int i = 0; i < 8; i++) hist[i] = zero_entry();
    endfunction

    // One pixel clock: drive inputs, predict, advance, compare aged predictions.
    task automatic cyc(input int h, input int v);
        exp_t e;
        bit   disp, hit;
        int   row, yo, col, ph;
        logic [7:0] bits;
        disp = (h < 640) && (v < 480);
        hpos = 10'(h); vpos = 10'(v); display_on_in = disp;
        hsync_in = 1'($urandom); vsync_in = 1'($urandom);
        if (!reset_n) begin
            e = zero_entry();
        end else begin
            if (v != m_prev && v == 0) begin
                m_frames++;
                m_synced = 1;
            end
            m_prev = v;
            row = (v / 12 > 63) ? 63 : v / 12;
            yo  = v % 12;
            col = h / 8;
            ph  = h % 8;
            if (disp) m_last = row * 80 + col;
            hit = cursor_en && (((m_frames >> 5) & 1) == 1) &&
                  (col == int'(cursor_col)) && (row == int'(cursor_row));
            e.fch  = int'(tmem[m_last]);
            bits   = rom[e.fch * 12 + yo];
            e.pix  = m_synced && disp && (bits[7-ph] ^ hit);
            e.hs   = hsync_in;
            e.vs   = vsync_in;
            e.disp = disp;
            e.addr = m_last;
            e.yofs = yo;
            e.chk_addr = m_synced;
            e.chk_font = m_synced;
        end
        hist[t % 8] = e;
        @(posedge clk);
        #1;
        if (hist[t % 8].chk_addr) check_eq("text_addr", int'(text_addr), hist[t % 8].addr);
        if (hist[(t + 6) % 8].chk_font) begin
            check_eq("font_char", int'(font_char), hist[(t + 6) % 8].fch);
            check_eq("font_yofs", int'(font_yofs), hist[(t + 6) % 8].yofs);
        end
        check_eq("pixel", int'(pixel), int'(hist[(t + 4) % 8].pix));
        check_eq("hsync_out", int'(hsync_out), int'(hist[(t + 4) % 8].hs));
        check_eq("vsync_out", int'(vsync_out), int'(hist[(t + 4) % 8].vs));
        check_eq("display_on_out", int'(display_on_out), int'(hist[(t + 4) % 8].disp));
        t++;
    endtask

    // Visits every line so the tracker sees each vpos change; cursor cell lines drawn in full.
    task automatic walk_lines(input int v0, input int v1, input bit full0);
        for (int v = v0; v <= v1; v++) begin
            if (v == 0 && full0) begin
                for (int h = 0; h < 800; h++) cyc(h, v);
            end else if (v >= 36 && v <= 47) begin
                for (int h = 32; h < 56; h++) cyc(h, v);
            end else begin
                cyc(17, v);
                if (v == 25 && m_synced) check_eq("addr_row2_col2", int'(text_addr), 162);
                cyc(int'($urandom_range(0, 799)), v);
                cyc(int'($urandom_range(640, 799)), v);
                cyc(639, v);
                if (v == 479 && m_synced) check_eq("addr_last_cell", int'(text_addr), 3199);
            end
        end
    endtask

    // In-flight font expectations were taken from the old contents; drop them.
    task automatic load_mem(input bit rand_rom, input logic [7:0] rom_fill);
        for (int i = 0; i < 3200; i++) tmem[i] = 8'($urandom);
        for (int i = 0; i < 3072; i++) rom[i] = rand_rom ? 8'($urandom) : rom_fill;
        tmem[3 * 80 + 5] = 8'h00;
        for (int i = 0; i < 12; i++) rom[i] = 8'h00;
        for (int i = 0; i < 8; i++) hist[i].chk_font = 0;
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_text_addr"}, int'(text_addr), 0);
        check_eq({tag, "_font_char"}, int'(font_char), 0);
        check_eq({tag, "_font_yofs"}, int'(font_yofs), 0);
        check_eq({tag, "_pixel"}, int'(pixel), 0);
        check_eq({tag, "_hsync"}, int'(hsync_out), 0);
        check_eq({tag, "_vsync"}, int'(vsync_out), 0);
        check_eq({tag, "_disp"}, int'(display_on_out), 0);
    endtask

    initial begin
        for (int i = 0; i < 3200; i++) tmem[i] = 8'h41;
        for (int i = 0; i < 3072; i++) rom[i] = 8'h81;
        cursor_en = 1'b1; cursor_col = 7'd5; cursor_row = 6'd3;
        model_reset();

        for (int i = 0; i < 3; i++) cyc(0, 524);
        check_all_zero("reset");
        reset_n = 1'b1;
        for (int i = 0; i < 2; i++) cyc(0, 524);

        // Frame 1: uniform 'A' glyph 0x81, cursor enabled but blink phase off.
        walk_lines(0, 524, 1'b1);

        // Frame 2: glyph rows all 0xFF to show blanking gates the pixel.
        load_mem(1'b0, 8'hFF);
        walk_lines(0, 524, 1'b1);

        // Step through frames quickly until the blink bit turns on.
        load_mem(1'b1, 8'h00);
        for (int k = 0; k < 29; k++) begin
            cyc(0, 0);
            cyc(0, 1);
        end
        walk_lines(0, 524, 1'b0);

        // Mid-frame asynchronous reset.
        walk_lines(0, 200, 1'b0);
        #2 reset_n = 1'b0;
        #1 check_all_zero("async_reset");
        model_reset();
        for (int i = 0; i < 3; i++) cyc(0, 200);
        reset_n = 1'b1;
        walk_lines(201, 524, 1'b0);
        walk_lines(0, 60, 1'b0);
        for (int i = 0; i < 6; i++) cyc(799, 60);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
